// File: rtl/chip8_sprite_draw_if.sv
// Signal bundle between a CHIP-8 sprite draw engine, its sprite memory and the framebuffer stage.
interface chip8_sprite_draw_if;
    logic        start;
    logic [7:0]  x;
    logic [7:0]  y;
    logic [3:0]  n;
    logic [11:0] i_addr;
    logic [11:0] mem_addr;
    logic [7:0]  mem_rdata;
    logic [7:0]  fb_vx;
    logic [7:0]  fb_vy;
    logic [7:0]  fb_rdata;
    logic [7:0]  fb_writedata;
    logic        fb_write;
    logic        busy;
    logic        done;
    logic        collision;

    modport slave (
        input  start, x, y, n, i_addr, mem_rdata, fb_rdata,
        output mem_addr, fb_vx, fb_vy, fb_writedata, fb_write, busy, done, collision
    );

    modport master (
        output start, x, y, n, i_addr, mem_rdata, fb_rdata,
        input  mem_addr, fb_vx, fb_vy, fb_writedata, fb_write, busy, done, collision
    );
endinterface

// File: rtl/chip8_sprite_draw.sv
// CHIP-8 DXYN sprite draw engine: fetches n sprite rows, XORs them into the framebuffer, reports VF.
// Define CHIP8_SPRITE_WRAP_EN to wrap rows vertically instead of clipping them at the bottom edge.
module chip8_sprite_draw (
    input logic                clk,
    input logic                reset,
    chip8_sprite_draw_if.slave draw_io
);
    typedef enum logic [2:0] {IDLE, MEM, FBRD, WR, DONE} state_t;

    state_t      state_q, state_d;
    logic [5:0]  x_q, x_d;
    logic [4:0]  y_q, y_d;
    logic [3:0]  n_q, n_d;
    logic [3:0]  r_q, r_d;
    logic [11:0] base_q, base_d;
    logic [7:0]  s_q, s_d;
    logic        coll_q, coll_d;

    logic [4:0]  row_vy;
    logic [3:0]  r_inc;
    logic        next_off;
    logic [7:0]  col_mask;
    logic [7:0]  hit;
    logic [7:0]  wr_data;
    logic        unused_upper_bits;

    // The origin is taken mod 64 / mod 32, so the upper coordinate bits are never consumed.
    assign unused_upper_bits = ^{draw_io.x[7:6], draw_io.y[7:5]};

    // 5-bit sum wraps mod 32; without wrap, off-screen rows never reach the framebuffer.
    assign row_vy = y_q + {1'b0, r_q};
    assign r_inc  = r_q + 4'd1;

`ifdef CHIP8_SPRITE_WRAP_EN
    assign next_off = 1'b0;
`else
    logic [5:0] next_row_sum;
    assign next_row_sum = {1'b0, y_q} + {2'b00, r_inc};
    assign next_off     = (next_row_sum > 6'd31);
`endif

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_col
            // Bit gi is pixel x+gi; sprite MSB is the leftmost pixel.
            assign col_mask[gi] = (({1'b0, x_q} + 7'(gi)) <= 7'd63);
            assign hit[gi]      = draw_io.fb_rdata[gi] & s_q[7-gi] & col_mask[gi];
            assign wr_data[gi]  = draw_io.fb_rdata[gi] ^ (s_q[7-gi] & col_mask[gi]);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            n_q     <= '0;
            r_q     <= '0;
            base_q  <= '0;
            s_q     <= '0;
            coll_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            n_q     <= n_d;
            r_q     <= r_d;
            base_q  <= base_d;
            s_q     <= s_d;
            coll_q  <= coll_d;
        end
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        n_d     = n_q;
        r_d     = r_q;
        base_d  = base_q;
        s_d     = s_q;
        coll_d  = coll_q;
        unique case (state_q)
            IDLE: begin
                if (draw_io.start) begin
                    x_d    = draw_io.x[5:0];
                    y_d    = draw_io.y[4:0];
                    n_d    = draw_io.n;
                    base_d = draw_io.i_addr;
                    r_d    = 4'd0;
                    coll_d = 1'b0;
                    // Row 0 sits at y mod 32 and is always on-screen, so only n=0 skips.
                    state_d = (draw_io.n == 4'd0) ? DONE : MEM;
                end
            end
            MEM:  state_d = FBRD;
            FBRD: begin
                s_d     = draw_io.mem_rdata;
                state_d = WR;
            end
            WR: begin
                if (|hit) begin
                    coll_d = 1'b1;
                end
                r_d     = r_inc;
                state_d = ((r_inc == n_q) || next_off) ? DONE : MEM;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Strobes are gated by reset so an abort suppresses the write of the current cycle too.
    assign draw_io.busy         = (state_q != IDLE);
    assign draw_io.done         = (state_q == DONE) && !reset;
    assign draw_io.fb_write     = (state_q == WR) && !reset;
    assign draw_io.mem_addr     = (state_q == MEM) ? (base_q + {8'h00, r_q}) : 12'h000;
    assign draw_io.fb_vx        = ((state_q == FBRD) || (state_q == WR)) ? {2'b00, x_q} : 8'h00;
    assign draw_io.fb_vy        = ((state_q == FBRD) || (state_q == WR)) ? {3'b000, row_vy} : 8'h00;
    assign draw_io.fb_writedata = (state_q == WR) ? wr_data : 8'h00;
    assign draw_io.collision    = coll_q;
endmodule
